ifu_fetch_ctrl: RTL and testbench
=================================

# ifu_fetch_ctrl

Central sequencer for the instruction-fetch pipeline. It takes redirect requests from the backend and IF3, stall conditions from the I-cache and the instruction buffer, and produces the per-stage pause/flush controls plus the single PC-redirect command consumed by IF0. It sits beside the IFU and drives every stage Ctrl bundle: IF0/1 regs, NLP, BPD s0/s1, I-cache, IF2/3 regs, IF3, IF3 output regs. It also sequences predictor recovery after a backend redirect.

## Interface
- BPD_RECOVER_CYC, 2, cycles the predictor needs for history recovery after a backend redirect (≥1)
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- be_redirect_valid  in  1  backend mispredict/exception redirect
- be_redirect_pc  in  32  backend target
- if3_redirect_valid  in  1  IF3 predecode redirect
- if3_redirect_pc  in  32  IF3 target
- icache_busy  in  1  I-cache miss/refill in progress, cannot accept a new PC
- ibuf_full  in  1  instruction buffer cannot accept a bundle this cycle
- stage_pause  out  8  per-stage pause, index order: IF01, NLP, BPD_S0, ICACHE, BPD_S1, IF23, IF3, IF3OUT
- stage_flush  out  8  per-stage flush, same order
- pc_redirect_valid  out  1  IF0 loads pc_redirect_pc this cycle
- pc_redirect_pc  out  32  redirect target
- fsm_state  out  2  debug: current state

## Operation
- States: RUN, RECOVER, DRAIN. Registers: state, pend_pc[31:0], pend_src (BE/IF3), rcnt.
- Flush masks: FLUSH_ALL = 8'hFF; FLUSH_YOUNG = 8'h3F (stages younger than IF3).
- Priority in every state: rst > be_redirect > if3_redirect > ibuf_full > icache_busy.
- RUN:
  - be_redirect_valid: flush FLUSH_ALL. Latch pend_pc, set pend_src=BE, load rcnt=BPD_RECOVER_CYC, go to RECOVER. No redirect issued this cycle. A coincident IF3 redirect is dropped.
  - if3_redirect_valid with !icache_busy: pc_redirect_valid=1 and pc_redirect_pc=if3_redirect_pc in the same cycle. Flush FLUSH_YOUNG. Stay in RUN.
  - if3_redirect_valid with icache_busy: latch pend_pc, set pend_src=IF3, go to DRAIN.
  - ibuf_full: stage_pause=8'hFF, no flush.
  - icache_busy: pause bits 0–4, flush bit 5 (bubble into IF23). Bits 6–7 keep running.
- RECOVER:
  - Flush FLUSH_ALL every cycle, except ICACHE, which is paused (not flushed) while icache_busy.
  - Decrement rcnt each cycle.
  - be_redirect_valid reloads pend_pc and rcnt, restarting the window.
  - IF3 redirects are ignored.
  - In the cycle rcnt==1: if !icache_busy, issue the redirect from pend_pc and go to RUN; otherwise go to DRAIN.
- DRAIN:
  - Flush the mask selected by pend_src; ICACHE is paused rather than flushed while busy. IF0 gets no redirect.
  - be_redirect_valid: go to RECOVER with the new target. IF3 redirects are ignored.
  - Exit cycle (icache_busy low): pc_redirect_valid=1 from pend_pc. Flush the pend_src mask including ICACHE, so the refill result is discarded. Go to RUN.
- Flush dominates pause on the same stage bit.
- In RUN, pc_redirect_pc is don't-care when pc_redirect_valid=0. Drive pend_pc.

## Timing
- Reset: state=RUN, pend_pc=0, pend_src=BE, rcnt=0. While rst is high: stage_flush=8'hFF, stage_pause=0, pc_redirect_valid=0, fsm_state=RUN.
- Reset mid-RECOVER or mid-DRAIN abandons the pending redirect.
- All outputs are Mealy/combinational on state and inputs; there are no registered outputs.
- IF3 redirect latency: 0 cycles when the cache is idle.
- Backend redirect latency: exactly BPD_RECOVER_CYC cycles from the request cycle to pc_redirect_valid when the cache is idle. Longer when busy: issued in the first cycle that both the window has ended and icache_busy is low.
- pc_redirect_valid is a single-cycle pulse, at most one per redirect.
- rcnt width: $clog2(BPD_RECOVER_CYC+1).

## Structure
- The shared defs header holds:
  - the state enum
  - stage index constants (STG_IF01 … STG_IF3OUT)
  - FLUSH_ALL and FLUSH_YOUNG
  - the redirect source enum
- One natural sub-module: fetch_recover_cnt. It is a loadable down-counter with a last-cycle flag.
- The top module holds the FSM, the pend_* registers and the output decode.

## Test plan
- Reset, then idle RUN with no inputs: all pause=0, flush=0, pc_redirect_valid=0. During rst, flush=8'hFF.
- if3_redirect_valid=1, pc=32'h8000_0100, cache idle: pc_redirect_valid=1 with 32'h8000_0100 the same cycle, flush=8'h3F.
- be_redirect to 32'hBFC0_0380 with BPD_RECOVER_CYC=2: flush=8'hFF for 2 cycles, then the redirect pulse in cycle +2. A simultaneous IF3 redirect in cycle 0 never appears.
- be_redirect while icache_busy stays high for 5 cycles: RECOVER then DRAIN. ICACHE bit paused (not flushed) until busy drops. Redirect is issued in the first non-busy cycle with flush=8'hFF.
- IF3 redirect during a miss, followed 1 cycle later by a backend redirect to 32'h8000_2000: the IF3 target is discarded; the only redirect pulse carries 32'h8000_2000.
- ibuf_full with icache_busy: pause=8'hFF, flush=0. Releasing ibuf_full while still busy gives pause=8'h1F, flush=8'h20.

Source files
------------

// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared definitions for the IFU fetch sequencer: FSM states, redirect sources,
// per-stage control bit positions and flush masks.
package ifu_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RECOVER = 2'd1,
    ST_DRAIN   = 2'd2
  } fetch_state_e;

  typedef enum logic {
    SRC_BE  = 1'b0,
    SRC_IF3 = 1'b1
  } redirect_src_e;

  localparam int STG_IF01   = 0;
  localparam int STG_NLP    = 1;
  localparam int STG_BPD_S0 = 2;
  localparam int STG_ICACHE = 3;
  localparam int STG_BPD_S1 = 4;
  localparam int STG_IF23   = 5;
  localparam int STG_IF3    = 6;
  localparam int STG_IF3OUT = 7;

  localparam logic [7:0] FLUSH_ALL   = 8'hFF;
  localparam logic [7:0] FLUSH_YOUNG = 8'h3F;

  // Cache-miss stall in RUN: hold everything up to BPD_S1, bubble into IF23.
  localparam logic [7:0] PAUSE_MISS  = 8'h1F;
  localparam logic [7:0] BUBBLE_IF23 = 8'h20;

  function automatic logic [7:0] src_flush_mask(input redirect_src_e src);
    return (src == SRC_BE) ? FLUSH_ALL : FLUSH_YOUNG;
  endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// Redirect/stall inputs and per-stage control outputs of the fetch sequencer.
// master = the sequencer, slave = the IFU stages and redirect sources.
interface ifu_fetch_ctrl_if;
  logic        be_redirect_valid;
  logic [31:0] be_redirect_pc;
  logic        if3_redirect_valid;
  logic [31:0] if3_redirect_pc;
  logic        icache_busy;
  logic        ibuf_full;
  logic [7:0]  stage_pause;
  logic [7:0]  stage_flush;
  logic        pc_redirect_valid;
  logic [31:0] pc_redirect_pc;

  modport master (
    input  be_redirect_valid, be_redirect_pc,
    input  if3_redirect_valid, if3_redirect_pc,
    input  icache_busy, ibuf_full,
    output stage_pause, stage_flush,
    output pc_redirect_valid, pc_redirect_pc
  );

  modport slave (
    output be_redirect_valid, be_redirect_pc,
    output if3_redirect_valid, if3_redirect_pc,
    output icache_busy, ibuf_full,
    input  stage_pause, stage_flush,
    input  pc_redirect_valid, pc_redirect_pc
  );
endinterface

// File: rtl/fetch_recover_cnt.sv
// Loadable down-counter timing the predictor history-recovery window;
// last is high in the final cycle of the window.
module fetch_recover_cnt #(
  parameter int WIDTH    = 2,
  parameter int LOAD_VAL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic last
);

  logic [WIDTH-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= WIDTH'(LOAD_VAL);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign last = (cnt == WIDTH'(1));

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch-pipeline sequencer: arbitrates backend/IF3 redirects against cache and
// ibuf stalls, drives per-stage pause/flush and the single IF0 PC redirect.
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int BPD_RECOVER_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  ifu_fetch_ctrl_if.master    bus,
  output logic [1:0]          fsm_state
);

  localparam int RCNT_W = $clog2(BPD_RECOVER_CYC + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pend_pc_q;
  redirect_src_e pend_src_q;

  logic          latch_pend;
  logic [31:0]   latch_pc;
  redirect_src_e latch_src;
  logic          rcnt_load, rcnt_dec, rcnt_last;

  logic [7:0]    flush, pause;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;

  fetch_recover_cnt #(
    .WIDTH    (RCNT_W),
    .LOAD_VAL (BPD_RECOVER_CYC)
  ) u_recover_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (rcnt_load),
    .dec  (rcnt_dec),
    .last (rcnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pend_pc_q  <= '0;
      pend_src_q <= SRC_BE;
    end else begin
      state_q <= state_d;
      if (latch_pend) begin
        pend_pc_q  <= latch_pc;
        pend_src_q <= latch_src;
      end
    end
  end

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    latch_pend     = 1'b0;
    latch_pc       = bus.be_redirect_pc;
    latch_src      = SRC_BE;
    rcnt_load      = 1'b0;
    rcnt_dec       = 1'b0;
    flush          = '0;
    pause          = '0;
    redirect_valid = 1'b0;
    redirect_pc    = pend_pc_q;

    unique case (state_q)
      ST_RUN: begin
        if (bus.be_redirect_valid) begin
          flush      = FLUSH_ALL;
          latch_pend = 1'b1;
          rcnt_load  = 1'b1;
          state_d    = ST_RECOVER;
        end else if (bus.if3_redirect_valid && !bus.icache_busy) begin
          redirect_valid = 1'b1;
          redirect_pc    = bus.if3_redirect_pc;
          flush          = FLUSH_YOUNG;
        end else if (bus.if3_redirect_valid) begin
          // Park the IF3 target until the refill completes; cache held meanwhile.
          latch_pend        = 1'b1;
          latch_pc          = bus.if3_redirect_pc;
          latch_src         = SRC_IF3;
          flush             = FLUSH_YOUNG;
          flush[STG_ICACHE] = 1'b0;
          pause[STG_ICACHE] = 1'b1;
          state_d           = ST_DRAIN;
        end else if (bus.ibuf_full) begin
          pause = 8'hFF;
        end else if (bus.icache_busy) begin
          pause = PAUSE_MISS;
          flush = BUBBLE_IF23;
        end
      end

      ST_RECOVER: begin
        flush    = FLUSH_ALL;
        rcnt_dec = 1'b1;
        if (bus.be_redirect_valid) begin
          latch_pend = 1'b1;
          rcnt_load  = 1'b1;
        end else if (rcnt_last) begin
          if (!bus.icache_busy) begin
            redirect_valid = 1'b1;
            state_d        = ST_RUN;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        flush = src_flush_mask(pend_src_q);
        if (bus.be_redirect_valid) begin
          flush      = FLUSH_ALL;
          latch_pend = 1'b1;
          rcnt_load  = 1'b1;
          state_d    = ST_RECOVER;
        end else if (!bus.icache_busy) begin
          redirect_valid = 1'b1;
          state_d        = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase

    // Outside RUN the outstanding refill is held, not discarded, until it ends.
    if ((state_q != ST_RUN) && bus.icache_busy) begin
      flush[STG_ICACHE] = 1'b0;
      pause[STG_ICACHE] = 1'b1;
    end
    if ((state_q != ST_RUN) && bus.ibuf_full) begin
      pause = 8'hFF;
    end

    if (rst) begin
      flush          = FLUSH_ALL;
      pause          = '0;
      redirect_valid = 1'b0;
    end
  end

  assign bus.stage_flush       = flush;
  assign bus.stage_pause       = pause & ~flush;
  assign bus.pc_redirect_valid = redirect_valid;
  assign bus.pc_redirect_pc    = redirect_pc;
  assign fsm_state             = rst ? ST_RUN : state_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: each scenario is a per-cycle table of
// inputs and hand-derived outputs, compared mid-cycle.
module tb_ifu_fetch_ctrl;
  import ifu_fetch_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] fsm_state;
  int         checks = 0;
  int         errors = 0;

  ifu_fetch_ctrl_if bus ();

  ifu_fetch_ctrl #(.BPD_RECOVER_CYC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_REC = 2'd1;
  localparam logic [1:0] S_DRN = 2'd2;

  typedef struct {
    logic        rst;
    logic        be;
    logic [31:0] bpc;
    logic        i3;
    logic [31:0] ipc;
    logic        busy;
    logic        full;
    logic [7:0]  p;
    logic [7:0]  f;
    logic        pv;
    logic [31:0] pc;
    logic [1:0]  st;
    logic        dc;   // pause/flush not compared in this cycle
  } vec_t;

  function automatic vec_t mk(input logic r, input logic be, input logic [31:0] bpc,
                              input logic i3, input logic [31:0] ipc,
                              input logic busy, input logic full,
                              input logic [7:0] p, input logic [7:0] f,
                              input logic pv, input logic [31:0] pc,
                              input logic [1:0] st, input logic dc);
    vec_t v;
    v = '{r, be, bpc, i3, ipc, busy, full, p, f, pv, pc, st, dc};
    return v;
  endfunction

  function automatic vec_t idle(input logic [1:0] st);
    return mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, st, 0);
  endfunction

  task automatic apply(input vec_t v);
    rst                    = v.rst;
    bus.be_redirect_valid  = v.be;
    bus.be_redirect_pc     = v.bpc;
    bus.if3_redirect_valid = v.i3;
    bus.if3_redirect_pc    = v.ipc;
    bus.icache_busy        = v.busy;
    bus.ibuf_full          = v.full;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    vec_t v[$];
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 0, 0, S_RUN, 0));
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 0, 0, S_RUN, 0));
    v.push_back(idle(S_RUN));
    v.push_back(idle(S_RUN));
    foreach (v[i]) begin
      logic [18:0] obs, exp, care;
      apply(v[i]);
      #4;
      obs  = {bus.stage_pause, bus.stage_flush, bus.pc_redirect_valid, fsm_state};
      exp  = {v[i].p, v[i].f, v[i].pv, v[i].st};
      care = v[i].dc ? 19'h7 : '1;
      checks++;
      if ((obs & care) !== (exp & care)) begin
        errors++;
        $display("FAIL reset[%0d]: pause/flush/pv/state got %h/%h/%b/%0d expected %h/%h/%b/%0d",
                 i, obs[18:11], obs[10:3], obs[2], obs[1:0], exp[18:11], exp[10:3], exp[2], exp[1:0]);
      end
      next_cycle();
    end
  endtask

  task automatic test_if3_idle;
    vec_t v[$];
    v.push_back(mk(0, 0, 0, 1, 32'h8000_0100, 0, 0, 8'h00, 8'h3F, 1, 32'h8000_0100, S_RUN, 0));
    v.push_back(idle(S_RUN));
    foreach (v[i]) begin
      logic [18:0] obs, exp, care;
      apply(v[i]);
      #4;
      obs  = {bus.stage_pause, bus.stage_flush, bus.pc_redirect_valid, fsm_state};
      exp  = {v[i].p, v[i].f, v[i].pv, v[i].st};
      care = v[i].dc ? 19'h7 : '1;
      checks++;
      if ((obs & care) !== (exp & care)) begin
        errors++;
        $display("FAIL if3_idle[%0d]: pause/flush/pv/state got %h/%h/%b/%0d expected %h/%h/%b/%0d",
                 i, obs[18:11], obs[10:3], obs[2], obs[1:0], exp[18:11], exp[10:3], exp[2], exp[1:0]);
      end
      if (v[i].pv) begin
        checks++;
        if (bus.pc_redirect_pc !== v[i].pc) begin
          errors++;
          $display("FAIL if3_idle[%0d] pc: got %h expected %h", i, bus.pc_redirect_pc, v[i].pc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_be_redirect;
    vec_t v[$];
    v.push_back(mk(0, 1, 32'hBFC0_0380, 1, 32'h8000_0100, 0, 0, 8'h00, 8'hFF, 0, 0, S_RUN, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 0, 0, S_REC, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 1, 32'hBFC0_0380, S_REC, 0));
    v.push_back(idle(S_RUN));
    v.push_back(idle(S_RUN));
    foreach (v[i]) begin
      logic [18:0] obs, exp, care;
      apply(v[i]);
      #4;
      obs  = {bus.stage_pause, bus.stage_flush, bus.pc_redirect_valid, fsm_state};
      exp  = {v[i].p, v[i].f, v[i].pv, v[i].st};
      care = v[i].dc ? 19'h7 : '1;
      checks++;
      if ((obs & care) !== (exp & care)) begin
        errors++;
        $display("FAIL be_redirect[%0d]: pause/flush/pv/state got %h/%h/%b/%0d expected %h/%h/%b/%0d",
                 i, obs[18:11], obs[10:3], obs[2], obs[1:0], exp[18:11], exp[10:3], exp[2], exp[1:0]);
      end
      if (v[i].pv) begin
        checks++;
        if (bus.pc_redirect_pc !== v[i].pc) begin
          errors++;
          $display("FAIL be_redirect[%0d] pc: got %h expected %h", i, bus.pc_redirect_pc, v[i].pc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_be_busy;
    vec_t v[$];
    v.push_back(mk(0, 1, 32'h8000_1000, 0, 0, 1, 0, 8'h00, 8'hFF, 0, 0, S_RUN, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h08, 8'hF7, 0, 0, S_REC, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h08, 8'hF7, 0, 0, S_REC, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h08, 8'hF7, 0, 0, S_DRN, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h08, 8'hF7, 0, 0, S_DRN, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 1, 32'h8000_1000, S_DRN, 0));
    v.push_back(idle(S_RUN));
    foreach (v[i]) begin
      logic [18:0] obs, exp, care;
      apply(v[i]);
      #4;
      obs  = {bus.stage_pause, bus.stage_flush, bus.pc_redirect_valid, fsm_state};
      exp  = {v[i].p, v[i].f, v[i].pv, v[i].st};
      care = v[i].dc ? 19'h7 : '1;
      checks++;
      if ((obs & care) !== (exp & care)) begin
        errors++;
        $display("FAIL be_busy[%0d]: pause/flush/pv/state got %h/%h/%b/%0d expected %h/%h/%b/%0d",
                 i, obs[18:11], obs[10:3], obs[2], obs[1:0], exp[18:11], exp[10:3], exp[2], exp[1:0]);
      end
      if (v[i].pv) begin
        checks++;
        if (bus.pc_redirect_pc !== v[i].pc) begin
          errors++;
          $display("FAIL be_busy[%0d] pc: got %h expected %h", i, bus.pc_redirect_pc, v[i].pc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_if3_busy;
    vec_t v[$];
    v.push_back(mk(0, 0, 0, 1, 32'h8000_0400, 1, 0, 8'h00, 8'h00, 0, 0, S_RUN, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h08, 8'h37, 0, 0, S_DRN, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h3F, 1, 32'h8000_0400, S_DRN, 0));
    v.push_back(idle(S_RUN));
    foreach (v[i]) begin
      logic [18:0] obs, exp, care;
      apply(v[i]);
      #4;
      obs  = {bus.stage_pause, bus.stage_flush, bus.pc_redirect_valid, fsm_state};
      exp  = {v[i].p, v[i].f, v[i].pv, v[i].st};
      care = v[i].dc ? 19'h7 : '1;
      checks++;
      if ((obs & care) !== (exp & care)) begin
        errors++;
        $display("FAIL if3_busy[%0d]: pause/flush/pv/state got %h/%h/%b/%0d expected %h/%h/%b/%0d",
                 i, obs[18:11], obs[10:3], obs[2], obs[1:0], exp[18:11], exp[10:3], exp[2], exp[1:0]);
      end
      if (v[i].pv) begin
        checks++;
        if (bus.pc_redirect_pc !== v[i].pc) begin
          errors++;
          $display("FAIL if3_busy[%0d] pc: got %h expected %h", i, bus.pc_redirect_pc, v[i].pc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_if3_then_be;
    vec_t v[$];
    v.push_back(mk(0, 0, 0, 1, 32'h8000_0200, 1, 0, 8'h00, 8'h00, 0, 0, S_RUN, 1));
    v.push_back(mk(0, 1, 32'h8000_2000, 1, 32'h8000_0300, 1, 0, 8'h00, 8'h00, 0, 0, S_DRN, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 0, 0, S_REC, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 1, 32'h8000_2000, S_REC, 0));
    v.push_back(idle(S_RUN));
    v.push_back(idle(S_RUN));
    foreach (v[i]) begin
      logic [18:0] obs, exp, care;
      apply(v[i]);
      #4;
      obs  = {bus.stage_pause, bus.stage_flush, bus.pc_redirect_valid, fsm_state};
      exp  = {v[i].p, v[i].f, v[i].pv, v[i].st};
      care = v[i].dc ? 19'h7 : '1;
      checks++;
      if ((obs & care) !== (exp & care)) begin
        errors++;
        $display("FAIL if3_then_be[%0d]: pause/flush/pv/state got %h/%h/%b/%0d expected %h/%h/%b/%0d",
                 i, obs[18:11], obs[10:3], obs[2], obs[1:0], exp[18:11], exp[10:3], exp[2], exp[1:0]);
      end
      if (v[i].pv) begin
        checks++;
        if (bus.pc_redirect_pc !== v[i].pc) begin
          errors++;
          $display("FAIL if3_then_be[%0d] pc: got %h expected %h", i, bus.pc_redirect_pc, v[i].pc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_ibuf_busy;
    vec_t v[$];
    v.push_back(mk(0, 0, 0, 0, 0, 1, 1, 8'hFF, 8'h00, 0, 0, S_RUN, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h1F, 8'h20, 0, 0, S_RUN, 0));
    v.push_back(idle(S_RUN));
    foreach (v[i]) begin
      logic [18:0] obs, exp, care;
      apply(v[i]);
      #4;
      obs  = {bus.stage_pause, bus.stage_flush, bus.pc_redirect_valid, fsm_state};
      exp  = {v[i].p, v[i].f, v[i].pv, v[i].st};
      care = v[i].dc ? 19'h7 : '1;
      checks++;
      if ((obs & care) !== (exp & care)) begin
        errors++;
        $display("FAIL ibuf_busy[%0d]: pause/flush/pv/state got %h/%h/%b/%0d expected %h/%h/%b/%0d",
                 i, obs[18:11], obs[10:3], obs[2], obs[1:0], exp[18:11], exp[10:3], exp[2], exp[1:0]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_recover;
    vec_t v[$];
    v.push_back(mk(0, 1, 32'h8000_3000, 0, 0, 0, 0, 8'h00, 8'hFF, 0, 0, S_RUN, 0));
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 0, 0, S_RUN, 0));
    v.push_back(idle(S_RUN));
    v.push_back(idle(S_RUN));
    v.push_back(idle(S_RUN));
    foreach (v[i]) begin
      logic [18:0] obs, exp, care;
      apply(v[i]);
      #4;
      obs  = {bus.stage_pause, bus.stage_flush, bus.pc_redirect_valid, fsm_state};
      exp  = {v[i].p, v[i].f, v[i].pv, v[i].st};
      care = v[i].dc ? 19'h7 : '1;
      checks++;
      if ((obs & care) !== (exp & care)) begin
        errors++;
        $display("FAIL reset_mid[%0d]: pause/flush/pv/state got %h/%h/%b/%0d expected %h/%h/%b/%0d",
                 i, obs[18:11], obs[10:3], obs[2], obs[1:0], exp[18:11], exp[10:3], exp[2], exp[1:0]);
      end
      next_cycle();
    end
  endtask

  initial begin
    apply(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 0, 0, S_RUN, 0));
    test_reset();
    test_if3_idle();
    test_be_redirect();
    test_be_busy();
    test_if3_busy();
    test_if3_then_be();
    test_ibuf_busy();
    test_reset_mid_recover();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
